trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Trap and return sequencer for the machine-mode CSR file. Accepts exception, interrupt and `mret` requests from the core and owns the CSR file's single address/write port while a trap is in flight. It performs the required CSR updates one per cycle (mepc, mcause, mstatus), then issues a PC redirect. When idle it passes the core's own CSR-instruction traffic straight through, so it is the sole arbiter of the CSR port.

## Interface
Parameters:
- `XLEN`, 32, data/PC width; only 32 is supported.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  rising-edge clock shared with the core and the CSR file.
- `reset_n`  in  1  asynchronous active-low reset.
- `pc`  in  32  PC of the instruction at the current boundary.
- `boundary`  in  1  core is at an instruction boundary; requests are sampled only when this is high.
- `exception_req`, `exception_code[3:0]`  in  1/4  synchronous exception and its cause code.
- `mret_req`  in  1  `mret` is executing.
- `irq_external`, `irq_timer`, `irq_software`  in  1 each  level interrupt lines, already synchronous.
- `global_ie`  in  1  mstatus.MIE from the CSR file.
- `irq_enable[2:0]`  in  3  mie {MEIE, MTIE, MSIE}.
- `core_csr_address[11:0]`, `core_csr_write_value[31:0]`, `core_csr_write_enable`  in  core CSR-instruction port.
- `csr_address[11:0]`, `csr_write_value[31:0]`, `csr_write_enable`  out  port to the CSR file.
- `csr_read_value[31:0]`  in  combinational read data from the CSR file.
- `busy`  out  1  core stall; high in every non-IDLE state.
- `redirect_valid`  out  1  one-cycle pulse; `redirect_pc` is valid.
- `redirect_pc[31:0]`  out  32  new PC.

## Operation
- States:
  - Trap path: IDLE, TRAP_EPC, TRAP_CAUSE, TRAP_STATUS, TRAP_VECTOR.
  - Return path: MRET_STATUS, MRET_EPC.
- Taken interrupt: `global_ie & |(irq lines & irq_enable)`.
- Interrupt priority: external (cause 11) > software (3) > timer (7).
- Acceptance in IDLE with `boundary`=1 uses the priority interrupt > exception > mret.
  - A lower-priority request arriving in the same cycle is dropped; the core re-issues it.
- On acceptance, the sequencer latches `pc`, the cause code and the interrupt flag.
  - Trap requests go to TRAP_EPC; mret goes to MRET_STATUS.
- TRAP_EPC: write mepc (0x341) = {pc[31:2], 2'b0}.
- TRAP_CAUSE: write mcause (0x342) = {interrupt, 27'b0, code[3:0]}.
- TRAP_STATUS: read-modify-write of mstatus (0x300) in a single cycle, since the read is combinational.
  - New MPIE = old MIE; new MIE = 0; all other bits are written back unchanged.
- TRAP_VECTOR: address mtvec (0x305); write enable low; pulse `redirect_valid`; return to IDLE.
- MRET_STATUS: mstatus write with new MIE = old MPIE and new MPIE = 1.
- MRET_EPC: address mepc; `redirect_pc` = {read[31:2], 2'b0}; pulse `redirect_valid`; return to IDLE.
- IDLE passes the `core_csr_*` inputs through to the `csr_*` outputs.
- In non-IDLE states the core port is ignored: its writes are discarded and the core is stalled by `busy`.
- Requests present while `busy` is high are not latched.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`, `redirect_valid` and `csr_write_enable` are 0.
  - `csr_address`, `csr_write_value` and `redirect_pc` are 0.
  - All latched fields are 0.
- During reset, the IDLE pass-through is gated off.
- Trap latency: accept at edge 0, then CSR writes on edges 1, 2 and 3. `redirect_valid` is high in the 4th cycle after acceptance (TRAP_VECTOR); `busy` drops on the following edge.
- mret latency: mstatus write on edge 1; `redirect_valid` is high in the 2nd cycle.
- `redirect_pc` is combinational from `csr_read_value` in the redirect cycle; the core samples it on that cycle's edge.
- Reset asserted mid-sequence: immediate return to IDLE and no further writes. CSR updates already performed are not rolled back.
- `csr_*` outputs are registered per state, except the pass-through mux and the mstatus read-modify-write value.

## Configuration
- `TRAP_SEQUENCER_VECTORED_EN` defined: honour mtvec MODE bit 0.
  - Interrupt with MODE=1: redirect = {base, 2'b0} + 4×cause.
  - Exceptions always go to base.
- Macro undefined: MODE is ignored and the redirect is always {mtvec[31:2], 2'b0}.

## Structure
- Shared package `trap_pkg` contains:
  - the state enum;
  - CSR address constants (mstatus, mtvec, mepc, mcause);
  - interrupt cause constants 3/7/11;
  - mstatus bit indices MIE=3 and MPIE=7.
- Sub-module `irq_priority_encoder`: combinational; takes the masked lines and produces `{taken, code[3:0]}`.

## Test plan
- Exception with code 11, pc=0x100, mtvec=0x200, mstatus.MIE=1:
  - writes mepc=0x100, then mcause=0x0000000B, then mstatus with MIE=0 and MPIE=1;
  - redirect to 0x200 in the 4th cycle.
- Timer irq with `global_ie`=1 and MTIE=1, mtvec=0x201:
  - mcause=0x80000007;
  - redirect 0x21C with the macro defined, 0x200 without.
- External, timer and exception all asserted in the same cycle:
  - mcause=0x8000000B and a single trap;
  - the exception is not latched.
- mret with mepc=0x106 and mstatus.MPIE=1:
  - mstatus MIE=1, MPIE=1;
  - redirect 0x104 in the 2nd cycle; `busy` is low afterwards.
- `reset_n` pulsed low during TRAP_CAUSE:
  - state goes to IDLE, all outputs go to 0, no mstatus write occurs;
  - mepc keeps the value already written.
- Core CSR write to mscratch (0x340) while idle is passed through. The same write issued during TRAP_EPC never reaches the port.

Source files
------------

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types and constants for the trap sequencer
//
// Purpose: state encoding, machine-mode CSR addresses, interrupt cause codes
// and mstatus bit positions used by trap_sequencer and irq_priority_encoder.
// Ports: none (package).
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_TRAP_EPC    = 3'd1,
    ST_TRAP_CAUSE  = 3'd2,
    ST_TRAP_STATUS = 3'd3,
    ST_TRAP_VECTOR = 3'd4,
    ST_MRET_STATUS = 3'd5,
    ST_MRET_EPC    = 3'd6
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Word-align an address (instruction fetch targets are 4-byte aligned).
  function automatic logic [31:0] align4(input logic [31:0] v);
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - fixed-priority machine interrupt selector
//
// Purpose: picks the highest-priority pending, enabled interrupt.
//   Priority: external (11) > software (3) > timer (7).
// Ports:
//   i_masked_irq[2:0]  in   {MEIP, MTIP, MSIP} already ANDed with enables and MIE
//   o_irq_sel[4:0]     out  {taken, cause[3:0]}; all zero when nothing is taken
module irq_priority_encoder
  import trap_pkg::*;
(
  input  logic [2:0] i_masked_irq,
  output logic [4:0] o_irq_sel
);

  always_comb begin
    o_irq_sel = 5'b0;
    if (i_masked_irq[2]) begin
      o_irq_sel = {1'b1, CAUSE_MEI};
    end else if (i_masked_irq[0]) begin
      o_irq_sel = {1'b1, CAUSE_MSI};
    end else if (i_masked_irq[1]) begin
      o_irq_sel = {1'b1, CAUSE_MTI};
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap/mret sequencer that owns the CSR write port
//
// Purpose: accepts interrupt, exception and mret requests at instruction
// boundaries, performs the mepc/mcause/mstatus updates one per cycle, then
// pulses a PC redirect. While idle the core's CSR port is passed through.
// Optional build macro: TRAP_SEQUENCER_VECTORED_EN (honour mtvec MODE for
// interrupts; default build always redirects to the mtvec base).
// Ports:
//   clock, reset_n                        clock, async active-low reset
//   pc, boundary                          current-boundary PC, sample strobe
//   exception_req, exception_code         synchronous exception and cause
//   mret_req                              mret executing
//   irq_external/irq_timer/irq_software   level interrupt lines
//   global_ie, irq_enable[2:0]            mstatus.MIE, mie {MEIE, MTIE, MSIE}
//   core_csr_address/write_value/enable   core CSR-instruction port
//   csr_address/write_value/write_enable  port to the CSR file
//   csr_read_value                        combinational CSR read data
//   busy                                  core stall while sequencing
//   redirect_valid, redirect_pc           one-cycle PC redirect
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc,
  input  logic            boundary,
  input  logic            exception_req,
  input  logic [3:0]      exception_code,
  input  logic            mret_req,
  input  logic            irq_external,
  input  logic            irq_timer,
  input  logic            irq_software,
  input  logic            global_ie,
  input  logic [2:0]      irq_enable,
  input  logic [11:0]     core_csr_address,
  input  logic [31:0]     core_csr_write_value,
  input  logic            core_csr_write_enable,
  output logic [11:0]     csr_address,
  output logic [31:0]     csr_write_value,
  output logic            csr_write_enable,
  input  logic [31:0]     csr_read_value,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [3:0]      r_code;
  logic            r_irq;

  logic [2:0]  w_masked_irq;
  logic [4:0]  w_irq_sel;
  logic        w_trap_req;
  logic [31:0] w_mstatus_rmw;
  logic [31:0] w_base;
  logic [31:0] w_trap_target;

  assign w_masked_irq = {irq_external, irq_timer, irq_software} & irq_enable & {3{global_ie}};

  irq_priority_encoder u_irq_priority_encoder (
    .i_masked_irq (w_masked_irq),
    .o_irq_sel    (w_irq_sel)
  );

  assign w_trap_req = w_irq_sel[4] | exception_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_code  <= '0;
      r_irq   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // An interrupt outranks a same-cycle exception, which outranks mret;
          // the losers are dropped and re-issued by the core.
          if (boundary && w_trap_req) begin
            r_pc    <= pc;
            r_irq   <= w_irq_sel[4];
            r_code  <= w_irq_sel[4] ? w_irq_sel[3:0] : exception_code;
            r_state <= ST_TRAP_EPC;
          end else if (boundary && mret_req) begin
            r_pc    <= pc;
            r_irq   <= 1'b0;
            r_code  <= 4'd0;
            r_state <= ST_MRET_STATUS;
          end
        end
        ST_TRAP_EPC:    r_state <= ST_TRAP_CAUSE;
        ST_TRAP_CAUSE:  r_state <= ST_TRAP_STATUS;
        ST_TRAP_STATUS: r_state <= ST_TRAP_VECTOR;
        ST_TRAP_VECTOR: r_state <= ST_IDLE;
        ST_MRET_STATUS: r_state <= ST_MRET_EPC;
        ST_MRET_EPC:    r_state <= ST_IDLE;
        default:        r_state <= ST_IDLE;
      endcase
    end
  end

  // mstatus read-modify-write happens in one cycle because the read is
  // combinational; only MIE/MPIE change, every other bit is written back.
  always_comb begin
    w_mstatus_rmw = csr_read_value;
    if (r_state == ST_TRAP_STATUS) begin
      w_mstatus_rmw[MSTATUS_MPIE] = csr_read_value[MSTATUS_MIE];
      w_mstatus_rmw[MSTATUS_MIE]  = 1'b0;
    end else if (r_state == ST_MRET_STATUS) begin
      w_mstatus_rmw[MSTATUS_MIE]  = csr_read_value[MSTATUS_MPIE];
      w_mstatus_rmw[MSTATUS_MPIE] = 1'b1;
    end
  end

  assign w_base = align4(csr_read_value);

`ifdef TRAP_SEQUENCER_VECTORED_EN
  // Vectored mode applies to interrupts only; exceptions land on the base.
  assign w_trap_target = (r_irq && csr_read_value[0]) ? (w_base + {26'b0, r_code, 2'b00}) : w_base;
`else
  assign w_trap_target = w_base;
`endif

  // Port drive is decoded from the state register; pass-through is gated
  // off while reset is asserted so the CSR file sees no traffic.
  always_comb begin
    csr_address      = 12'h000;
    csr_write_value  = 32'h0;
    csr_write_enable = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    if (reset_n) begin
      case (r_state)
        ST_IDLE: begin
          csr_address      = core_csr_address;
          csr_write_value  = core_csr_write_value;
          csr_write_enable = core_csr_write_enable;
        end
        ST_TRAP_EPC: begin
          csr_address      = CSR_MEPC;
          csr_write_value  = align4(r_pc);
          csr_write_enable = 1'b1;
        end
        ST_TRAP_CAUSE: begin
          csr_address      = CSR_MCAUSE;
          csr_write_value  = {r_irq, 27'b0, r_code};
          csr_write_enable = 1'b1;
        end
        ST_TRAP_STATUS, ST_MRET_STATUS: begin
          csr_address      = CSR_MSTATUS;
          csr_write_value  = w_mstatus_rmw;
          csr_write_enable = 1'b1;
        end
        ST_TRAP_VECTOR: begin
          csr_address    = CSR_MTVEC;
          redirect_valid = 1'b1;
          redirect_pc    = w_trap_target;
        end
        ST_MRET_EPC: begin
          csr_address    = CSR_MEPC;
          redirect_valid = 1'b1;
          redirect_pc    = w_base;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - self-checking bench for trap_sequencer
module tb_trap_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        boundary = 1'b0;
  logic        exception_req = 1'b0;
  logic [3:0]  exception_code = 4'd0;
  logic        mret_req = 1'b0;
  logic        irq_external = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_software = 1'b0;
  logic        global_ie = 1'b0;
  logic [2:0]  irq_enable = 3'b000;
  logic [11:0] core_csr_address = 12'h0;
  logic [31:0] core_csr_write_value = 32'h0;
  logic        core_csr_write_enable = 1'b0;
  logic [11:0] csr_address;
  logic [31:0] csr_write_value;
  logic        csr_write_enable;
  logic [31:0] csr_read_value;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clock = ~clock;

  // CSR file environment (driven by the DUT) and the model's own shadow copy.
  bit [31:0] env_mem [0:4095];
  bit [31:0] sh_mem  [0:4095];
  assign csr_read_value = env_mem[csr_address];

  trap_sequencer #(.XLEN(32)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .pc                    (pc),
    .boundary              (boundary),
    .exception_req         (exception_req),
    .exception_code        (exception_code),
    .mret_req              (mret_req),
    .irq_external          (irq_external),
    .irq_timer             (irq_timer),
    .irq_software          (irq_software),
    .global_ie             (global_ie),
    .irq_enable            (irq_enable),
    .core_csr_address      (core_csr_address),
    .core_csr_write_value  (core_csr_write_value),
    .core_csr_write_enable (core_csr_write_enable),
    .csr_address           (csr_address),
    .csr_write_value       (csr_write_value),
    .csr_write_enable      (csr_write_enable),
    .csr_read_value        (csr_read_value),
    .busy                  (busy),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
  } step_t;

  step_t       exp_q [$];
  step_t       cur;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_rv_seen = 0;
  logic [31:0] last_rpc = 32'h0;
  logic        pend_we = 1'b0;
  logic [11:0] pend_addr = 12'h0;
  logic [31:0] pend_data = 32'h0;
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = 12'h0;
  logic [31:0] bd_data = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    return (pend_we && pend_addr == a) ? pend_data : sh_mem[a];
  endfunction

  // Expected cycle-by-cycle port activity for one accepted request,
  // derived from the architectural trap/mret rules.
  task automatic build_trace();
    logic        is_irq;
    logic [3:0]  cause;
    logic [31:0] ms, nms, tv, tgt, ep;
    step_t       s;
    is_irq = global_ie && ((irq_external && irq_enable[2]) ||
                           (irq_timer && irq_enable[1]) ||
                           (irq_software && irq_enable[0]));
    if (is_irq) begin
      if (irq_external && irq_enable[2]) cause = 4'd11;
      else if (irq_software && irq_enable[0]) cause = 4'd3;
      else cause = 4'd7;
    end else begin
      cause = exception_code;
    end
    if (is_irq || exception_req) begin
      s = '{addr: 12'h341, we: 1'b1, wdata: {pc[31:2], 2'b00}, rv: 1'b0, rpc: 32'h0};
      exp_q.push_back(s);
      s = '{addr: 12'h342, we: 1'b1, wdata: {is_irq, 27'b0, cause}, rv: 1'b0, rpc: 32'h0};
      exp_q.push_back(s);
      ms = model_rd(12'h300);
      nms = ms;
      nms[7] = ms[3];
      nms[3] = 1'b0;
      s = '{addr: 12'h300, we: 1'b1, wdata: nms, rv: 1'b0, rpc: 32'h0};
      exp_q.push_back(s);
      tv = model_rd(12'h305);
      tgt = {tv[31:2], 2'b00};
`ifdef TRAP_SEQUENCER_VECTORED_EN
      if (is_irq && tv[0]) tgt = tgt + 32'd4 * 32'(cause);
`endif
      s = '{addr: 12'h305, we: 1'b0, wdata: 32'h0, rv: 1'b1, rpc: tgt};
      exp_q.push_back(s);
    end else if (mret_req) begin
      ms = model_rd(12'h300);
      nms = ms;
      nms[3] = ms[7];
      nms[7] = 1'b1;
      s = '{addr: 12'h300, we: 1'b1, wdata: nms, rv: 1'b0, rpc: 32'h0};
      exp_q.push_back(s);
      ep = model_rd(12'h341);
      s = '{addr: 12'h341, we: 1'b0, wdata: 32'h0, rv: 1'b1, rpc: {ep[31:2], 2'b00}};
      exp_q.push_back(s);
    end
  endtask

  // Compare process: outputs are sampled on the falling edge.
  always @(negedge clock) begin
    pend_we = 1'b0;
    if (redirect_valid) begin
      n_rv_seen++;
      last_rpc = redirect_pc;
    end
    if (!reset_n) begin
      exp_q.delete();
      chk("rst_addr", 32'(csr_address), 32'h0);
      chk("rst_wdata", csr_write_value, 32'h0);
      chk("rst_we", 32'(csr_write_enable), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rv", 32'(redirect_valid), 32'h0);
      chk("rst_rpc", redirect_pc, 32'h0);
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("seq_busy", 32'(busy), 32'h1);
      chk("seq_addr", 32'(csr_address), 32'(cur.addr));
      chk("seq_we", 32'(csr_write_enable), 32'(cur.we));
      if (cur.we) chk("seq_wdata", csr_write_value, cur.wdata);
      chk("seq_rv", 32'(redirect_valid), 32'(cur.rv));
      if (cur.rv) chk("seq_rpc", redirect_pc, cur.rpc);
      pend_we = cur.we;
      pend_addr = cur.addr;
      pend_data = cur.wdata;
    end else begin
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_addr", 32'(csr_address), 32'(core_csr_address));
      chk("idle_we", 32'(csr_write_enable), 32'(core_csr_write_enable));
      chk("idle_wdata", csr_write_value, core_csr_write_value);
      chk("idle_rv", 32'(redirect_valid), 32'h0);
      pend_we = core_csr_write_enable;
      pend_addr = core_csr_address;
      pend_data = core_csr_write_value;
      if (boundary) build_trace();
    end
  end

  // CSR file write port, bench backdoor, and shadow commit.
  always @(posedge clock) begin
    if (bd_we) begin
      env_mem[bd_addr] <= bd_data;
      sh_mem[bd_addr] <= bd_data;
    end else begin
      if (csr_write_enable) env_mem[csr_address] <= csr_write_value;
      if (pend_we && reset_n) sh_mem[pend_addr] <= pend_data;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic bd(input logic [11:0] a, input logic [31:0] d);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    cyc();
    bd_we = 1'b0;
  endtask

  int rv_before;

  initial begin
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();

    // Requests that must not be taken: no boundary, MIE clear, line not enabled.
    bd(12'h300, 32'h8);
    bd(12'h305, 32'h200);
    exception_req = 1'b1;
    exception_code = 4'd2;
    repeat (3) cyc();
    exception_req = 1'b0;
    boundary = 1'b1;
    irq_timer = 1'b1;
    irq_enable = 3'b010;
    repeat (2) cyc();
    global_ie = 1'b1;
    irq_enable = 3'b101;
    repeat (2) cyc();
    irq_timer = 1'b0;
    global_ie = 1'b0;
    irq_enable = 3'b000;
    cyc();
    chk("lit_no_trap", 32'(n_rv_seen), 32'd0);

    // Exception code 11 from pc 0x100.
    pc = 32'h100;
    exception_code = 4'd11;
    exception_req = 1'b1;
    cyc();
    exception_req = 1'b0;
    repeat (5) cyc();
    chk("lit_exc_mepc", env_mem[12'h341], 32'h100);
    chk("lit_exc_mcause", env_mem[12'h342], 32'h0000000B);
    chk("lit_exc_mstatus", env_mem[12'h300], 32'h80);
    chk("lit_exc_rpc", last_rpc, 32'h200);
    chk("lit_exc_busy", 32'(busy), 32'h0);

    // Timer interrupt, mtvec MODE=1.
    bd(12'h300, 32'h8);
    bd(12'h305, 32'h201);
    global_ie = 1'b1;
    irq_enable = 3'b010;
    irq_timer = 1'b1;
    pc = 32'h104;
    cyc();
    irq_timer = 1'b0;
    repeat (5) cyc();
    chk("lit_tmr_mcause", env_mem[12'h342], 32'h80000007);
    chk("lit_tmr_mepc", env_mem[12'h341], 32'h104);
`ifdef TRAP_SEQUENCER_VECTORED_EN
    chk("lit_tmr_rpc", last_rpc, 32'h21C);
`else
    chk("lit_tmr_rpc", last_rpc, 32'h200);
`endif

    // External + timer + exception together; exception held while busy.
    rv_before = n_rv_seen;
    irq_enable = 3'b111;
    irq_external = 1'b1;
    irq_timer = 1'b1;
    exception_req = 1'b1;
    exception_code = 4'd5;
    pc = 32'h108;
    cyc();
    irq_external = 1'b0;
    irq_timer = 1'b0;
    repeat (3) cyc();
    exception_req = 1'b0;
    repeat (4) cyc();
    chk("lit_pri_mcause", env_mem[12'h342], 32'h8000000B);
    chk("lit_pri_traps", 32'(n_rv_seen - rv_before), 32'd1);
`ifdef TRAP_SEQUENCER_VECTORED_EN
    chk("lit_pri_rpc", last_rpc, 32'h22C);
`else
    chk("lit_pri_rpc", last_rpc, 32'h200);
`endif

    // mret with mepc=0x106, MPIE=1.
    global_ie = 1'b0;
    irq_enable = 3'b000;
    bd(12'h341, 32'h106);
    bd(12'h300, 32'h80);
    mret_req = 1'b1;
    pc = 32'h200;
    cyc();
    mret_req = 1'b0;
    repeat (4) cyc();
    chk("lit_mret_mstatus", env_mem[12'h300], 32'h88);
    chk("lit_mret_rpc", last_rpc, 32'h104);
    chk("lit_mret_busy", 32'(busy), 32'h0);

    // Reset pulse during TRAP_CAUSE.
    bd(12'h300, 32'h8);
    exception_req = 1'b1;
    exception_code = 4'd2;
    pc = 32'h300;
    cyc();
    exception_req = 1'b0;
    cyc();
    reset_n = 1'b0;
    #1;
    chk("lit_rst_busy", 32'(busy), 32'h0);
    chk("lit_rst_we", 32'(csr_write_enable), 32'h0);
    cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("lit_rst_mepc", env_mem[12'h341], 32'h300);
    chk("lit_rst_mcause", env_mem[12'h342], 32'h8000000B);
    chk("lit_rst_mstatus", env_mem[12'h300], 32'h8);

    // Core mscratch write: passed while idle, discarded during TRAP_EPC.
    core_csr_address = 12'h340;
    core_csr_write_value = 32'hCAFEF00D;
    core_csr_write_enable = 1'b1;
    cyc();
    core_csr_write_enable = 1'b0;
    core_csr_address = 12'h0;
    core_csr_write_value = 32'h0;
    cyc();
    chk("lit_pass_mscratch", env_mem[12'h340], 32'hCAFEF00D);
    exception_req = 1'b1;
    exception_code = 4'd4;
    pc = 32'h400;
    cyc();
    exception_req = 1'b0;
    core_csr_address = 12'h340;
    core_csr_write_value = 32'hDEADBEEF;
    core_csr_write_enable = 1'b1;
    cyc();
    core_csr_write_enable = 1'b0;
    core_csr_address = 12'h0;
    core_csr_write_value = 32'h0;
    repeat (4) cyc();
    chk("lit_block_mscratch", env_mem[12'h340], 32'hCAFEF00D);
    chk("lit_block_mepc", env_mem[12'h341], 32'h400);

    foreach (sh_mem[i]) begin
      if (i == 12'h300 || i == 12'h305 || i == 12'h340 || i == 12'h341 || i == 12'h342)
        chk("shadow", env_mem[i], sh_mem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
